// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the shared register-file write port: ALU has priority,
// the memory unit is forced through after STARVE_LIMIT stalled cycles. Also tracks pending writes.
module regfile_wb_arbiter #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 5,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_addr,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              rsv_valid,
   input  logic [ADDR_W-1:0] rsv_addr,
   input  logic [ADDR_W-1:0] chk1_addr,
   input  logic [ADDR_W-1:0] chk2_addr,
   output logic              chk1_busy,
   output logic              chk2_busy,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_wr_addr,
   output logic [DATA_W-1:0] rf_wr_data,
   output logic              rsv_conflict
);

   localparam int NREG = 1 << ADDR_W;

   logic [3:0]        wait_cnt;
   logic              force_mem;
   logic              alu_grant;
   logic              mem_grant;
   logic              grant;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_data;
   logic              rsv_set;
   logic              rsv_clr_same;
   logic [NREG-1:0]   busy;
   logic [NREG-1:0]   busy_nxt;

   assign force_mem = (wait_cnt >= 4'(STARVE_LIMIT));
   assign alu_ready = rst_n && !force_mem;
   assign mem_ready = rst_n && (force_mem || !alu_valid);

   assign alu_grant = alu_valid && alu_ready;
   assign mem_grant = mem_valid && mem_ready;
   assign grant     = alu_grant || mem_grant;
   assign win_addr  = mem_grant ? mem_addr : alu_addr;
   assign win_data  = mem_grant ? mem_data : alu_data;

   assign rsv_set      = rsv_valid && (rsv_addr != '0);
   assign rsv_clr_same = grant && (win_addr == rsv_addr);

   // Set is applied after clear so a same-edge reservation survives the writeback.
   always_comb begin
      busy_nxt = busy;
      if (grant)
         busy_nxt[win_addr] = 1'b0;
      if (rsv_set)
         busy_nxt[rsv_addr] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wait_cnt     <= '0;
         busy         <= '0;
         rsv_conflict <= 1'b0;
         rf_we        <= 1'b0;
         rf_wr_addr   <= '0;
         rf_wr_data   <= '0;
      end else begin
         if (!mem_valid || mem_grant)
            wait_cnt <= '0;
         else if (wait_cnt != 4'd15)
            wait_cnt <= wait_cnt + 4'd1;

         busy         <= busy_nxt;
         rsv_conflict <= rsv_set && busy[rsv_addr] && !rsv_clr_same;

         rf_we <= grant && (win_addr != '0);
         if (grant) begin
            rf_wr_addr <= win_addr;
            rf_wr_data <= win_data;
         end
      end
   end

   // The output-stage term covers the cycle before the register file commits.
   assign chk1_busy = (chk1_addr != '0) &&
                      (busy[chk1_addr] || (rf_we && (rf_wr_addr == chk1_addr)));
   assign chk2_busy = (chk2_addr != '0) &&
                      (busy[chk2_addr] || (rf_we && (rf_wr_addr == chk2_addr)));

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback sources: the ALU (priority) and the multi-cycle memory/load unit.
- Uses fixed priority with an anti-starvation guard.
- Registers the winning write into the register file's write port (write enable, write address, write data).
- Keeps a pending-write scoreboard so the issue stage can stall on read-after-write hazards.

Parameters:
- DATA_W, 32, writeback data width; must match the register file data width.
- ADDR_W, 5, register address width; the scoreboard has 2**ADDR_W entries.
- STARVE_LIMIT, 4, consecutive stalled cycles of a valid memory request before it is forced to win (legal 1..15).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- alu_valid  input  1  ALU writeback request.
- alu_ready  output  1  ALU request accepted this cycle when high together with alu_valid.
- alu_addr  input  ADDR_W  ALU destination register.
- alu_data  input  DATA_W  ALU result.
- mem_valid  input  1  memory-unit writeback request.
- mem_ready  output  1  memory request accepted this cycle when high together with mem_valid.
- mem_addr  input  ADDR_W  memory destination register.
- mem_data  input  DATA_W  load data.
- rsv_valid  input  1  issue stage reserves a destination register.
- rsv_addr  input  ADDR_W  register being reserved.
- chk1_addr  input  ADDR_W  source register 1 hazard-check address.
- chk2_addr  input  ADDR_W  source register 2 hazard-check address.
- chk1_busy  output  1  source 1 has a write not yet visible in the register file.
- chk2_busy  output  1  source 2 has a write not yet visible in the register file.
- rf_we  output  1  drives the register-file write enable (`ENABLE when high).
- rf_wr_addr  output  ADDR_W  drives the register-file write address.
- rf_wr_data  output  DATA_W  drives the register-file write data.
- rsv_conflict  output  1  one-cycle pulse: reservation hit an already-busy register.

Behaviour:
- Reset (rst_n low at a rising edge):
  - rf_we=0, rf_wr_addr=0, rf_wr_data=0.
  - Scoreboard all 0; wait counter 0; rsv_conflict=0.
  - An accepted write whose output stage had not yet been loaded is discarded.
  - alu_ready and mem_ready are held 0 while rst_n is low.
- Arbitration (combinational readies, at most one grant per cycle):
  - force_mem = (wait_cnt >= STARVE_LIMIT).
  - alu_ready = !force_mem.
  - mem_ready = force_mem || !alu_valid.
- Wait counter:
  - Increments (saturating at 15) when mem_valid && !mem_ready.
  - Clears when mem_valid is low or the memory handshake completes.
- Output stage:
  - Handshake in cycle N loads rf_wr_addr and rf_wr_data at edge N+1; rf_we=1 for exactly one cycle.
  - The register file commits the write at edge N+2.
  - With no grant in cycle N, rf_we=0 in cycle N+1; address and data hold their previous values.
  - A granted write to register 0 is accepted (ready asserted, handshake completes) but produces rf_we=0.
- Scoreboard, busy[2**ADDR_W-1:0]:
  - Set: rsv_valid && rsv_addr!=0 sets busy[rsv_addr] at the next edge.
  - Clear: a granted write clears busy[addr] at the next edge.
  - Same edge, same address, set and clear: set wins.
  - rsv_valid to an address already busy (and not cleared this cycle): busy stays 1 and rsv_conflict pulses high for the next cycle only.
  - Register 0 is never busy.
- Hazard check (combinational):
  - chkX_busy = (chkX_addr!=0) && (busy[chkX_addr] || (rf_we && rf_wr_addr==chkX_addr)).
  - This covers the cycle in which the write sits in the output stage but is not yet in the register file.
  - A reservation in the current cycle is not reflected until the next cycle.
- Requesters must hold valid, addr and data stable until their handshake completes.
  - Arbiter behaviour is undefined if they do not.

Test Plan:
- ALU only: alu_valid=1, alu_addr=3, alu_data=0x11 in cycle N -> alu_ready=1 in N; rf_we=1, rf_wr_addr=3, rf_wr_data=0x11 in N+1; rf_we=0 in N+2.
- Contention and starvation, STARVE_LIMIT=4: ALU and memory both valid every cycle (ALU to r5, memory to r7) -> ALU wins 4 consecutive cycles; 5th cycle mem_ready=1, alu_ready=0, rf_wr_addr=7 one cycle later; counter returns to 0 and the ALU wins again.
- Scoreboard: reserve r9 -> chk1_addr=9 reads busy from the next cycle; memory write to r9 granted in cycle N -> chk1_busy stays 1 through N+1 (output stage) and is 0 from N+2.
- Set/clear collision: in one cycle the r4 writeback is granted and rsv_valid targets r4 -> busy[4]=1 afterwards and rsv_conflict=0; a second reservation of r4 -> rsv_conflict=1 for exactly one cycle.
- Register 0: reserve r0 and ALU write to r0 with data 0xFF -> alu_ready=1, rf_we stays 0, chk1_busy for address 0 stays 0.
- Reset mid-operation: grant in cycle N and rst_n=0 sampled at edge N+1 -> rf_we=0, scoreboard cleared, wait counter 0; no write reaches the register file.
